hls_run_sequencer: RTL and testbench

Host-side initiator for the ap_ctrl_hs block-level handshake exposed by our HLS cores (including the key-locked top_function). It provisions the core's working key from a narrow word stream, then issues a requested number of back-to-back invocations: it drives ap_start, consumes ap_ready/ap_done/ap_idle, counts completions and reports hang timeouts. It sits between the system controller and the callee core.

---
 rtl/hls_run_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_hls_run_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer: host-side initiator for the ap_ctrl_hs handshake of an HLS core.
// It loads the callee's working key from a narrow word stream. It then issues a
// requested number of back-to-back invocations. It counts completions and aborts
// any phase that hangs longer than TIMEOUT cycles.
//
// Ports
//   ap_clk, ap_rst_n        clock (rising edge), asynchronous active-low reset
//   key_valid/key_data      key word stream, word 0 = key bits [WORD_W-1:0]
//   key_ready               key word accepted on key_valid && key_ready (decoded)
//   key_loaded              full key present on working_key
//   working_key             key driven to the callee
//   run_valid/run_count     run request and number of invocations
//   run_ready               run accepted on run_valid && run_ready (decoded)
//   ap_start                to callee; ap_ready/ap_done/ap_idle from callee
//   busy, run_done          run in progress, one-cycle end-of-run pulse
//   done_count, timeout_err completions in current/last run, last run timed out
module hls_run_sequencer #(
    parameter int unsigned KEY_W   = 1535,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              key_valid,
    input  logic [WORD_W-1:0] key_data,
    output logic              key_ready,
    output logic              key_loaded,
    output logic [KEY_W-1:0]  working_key,
    input  logic              run_valid,
    input  logic [CNT_W-1:0]  run_count,
    output logic              run_ready,
    output logic              ap_start,
    input  logic              ap_ready,
    input  logic              ap_done,
    input  logic              ap_idle,
    output logic              busy,
    output logic              run_done,
    output logic [CNT_W-1:0]  done_count,
    output logic              timeout_err
);

    localparam int unsigned NWORDS = (KEY_W + WORD_W - 1) / WORD_W;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ARM, ST_START, ST_WAIT} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               key_loaded_q, key_loaded_d;
    logic               ap_start_q, ap_start_d;
    logic               busy_q, busy_d;
    logic               run_done_q, run_done_d;
    logic [CNT_W-1:0]   done_q, done_d;
    logic               terr_q, terr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               key_wr, tmr_exp, do_complete, do_abort;

    // Handshake readies are decoded from state; key loading outranks run requests.
    assign key_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign run_ready = (state_q == ST_IDLE) && key_loaded_q && !key_valid;
    assign key_wr    = key_valid && key_ready;
    assign tmr_exp   = (tmr_q == TMR_W'(TIMEOUT - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        key_loaded_d = key_loaded_q;
        ap_start_d   = ap_start_q;
        busy_d       = busy_q;
        run_done_d   = 1'b0;
        done_d       = done_q;
        terr_d       = terr_q;
        rem_d        = rem_q;
        tmr_d        = tmr_q;
        do_complete  = 1'b0;
        do_abort     = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (key_wr) begin
                    if (idx_q == IDX_W'(NWORDS - 1)) begin
                        key_loaded_d = 1'b1;
                        idx_d        = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        key_loaded_d = 1'b0;
                        idx_d        = idx_q + IDX_W'(1);
                        state_d      = ST_LOAD;
                    end
                end else if (run_valid && run_ready) begin
                    rem_d  = run_count;
                    done_d = '0;
                    terr_d = 1'b0;
                    if (run_count == '0) begin
                        run_done_d = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        tmr_d   = '0;
                        state_d = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (ap_idle) begin
                    ap_start_d = 1'b1;
                    tmr_d      = '0;
                    state_d    = ST_START;
                end else if (tmr_exp) begin
                    do_abort = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_START: begin
                if (ap_ready) begin
                    ap_start_d = 1'b0;
                    if (ap_done) begin
                        do_complete = 1'b1;
                    end else begin
                        tmr_d   = '0;
                        state_d = ST_WAIT;
                    end
                end else if (tmr_exp) begin
                    do_abort = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WAIT: begin
                if (ap_done) begin
                    do_complete = 1'b1;
                end else if (tmr_exp) begin
                    do_abort = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Invocation finished: count it, then re-arm or close the run.
        if (do_complete) begin
            if (done_q != '1) done_d = done_q + CNT_W'(1);
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
                run_done_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end else begin
                tmr_d   = '0;
                state_d = ST_ARM;
            end
        end

        // Hung phase: drop ap_start and close the run with the sticky error.
        if (do_abort) begin
            ap_start_d = 1'b0;
            terr_d     = 1'b1;
            run_done_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            key_loaded_q <= 1'b0;
            ap_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            run_done_q   <= 1'b0;
            done_q       <= '0;
            terr_q       <= 1'b0;
            rem_q        <= '0;
            tmr_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            key_loaded_q <= key_loaded_d;
            ap_start_q   <= ap_start_d;
            busy_q       <= busy_d;
            run_done_q   <= run_done_d;
            done_q       <= done_d;
            terr_q       <= terr_d;
            rem_q        <= rem_d;
            tmr_q        <= tmr_d;
        end
    end

    // Key storage, one register per stream word; the last word keeps only the bits below KEY_W.
    for (genvar w = 0; w < NWORDS; w++) begin : g_key
        localparam int unsigned LO  = w * WORD_W;
        localparam int unsigned WID = ((KEY_W - LO) < WORD_W) ? (KEY_W - LO) : WORD_W;
        logic [WID-1:0] word_q;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                word_q <= '0;
            end else if (key_wr && (idx_q == IDX_W'(w))) begin
                word_q <= key_data[WID-1:0];
            end
        end

        assign working_key[LO +: WID] = word_q;
    end

    assign key_loaded  = key_loaded_q;
    assign ap_start    = ap_start_q;
    assign busy        = busy_q;
    assign run_done    = run_done_q;
    assign done_count  = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Bench for hls_run_sequencer: behavioural callee, scoreboard of per-run results
// checked by a monitor on every run_done pulse, plus directed key/reset checks.
module tb_hls_run_sequencer;

    localparam int unsigned KEY_W   = 1535;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 16;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_COMB   = 1;
    localparam int MODE_HANG   = 2;

    logic              clk;
    logic              rst_n;
    logic              key_valid;
    logic [WORD_W-1:0] key_data;
    logic              key_ready;
    logic              key_loaded;
    logic [KEY_W-1:0]  working_key;
    logic              run_valid;
    logic [CNT_W-1:0]  run_count;
    logic              run_ready;
    logic              ap_start;
    logic              ap_ready;
    logic              ap_done;
    logic              ap_idle;
    logic              busy;
    logic              run_done;
    logic [CNT_W-1:0]  done_count;
    logic              timeout_err;

    hls_run_sequencer #(
        .KEY_W  (KEY_W),
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .key_ready  (key_ready),
        .key_loaded (key_loaded),
        .working_key(working_key),
        .run_valid  (run_valid),
        .run_count  (run_count),
        .run_ready  (run_ready),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .busy       (busy),
        .run_done   (run_done),
        .done_count (done_count),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int mode     = MODE_NORMAL;

    // Expected {done_count, timeout_err} per run, in issue order.
    logic [CNT_W:0] sb_q[$];

    int episodes  = 0;   // rising edges of ap_start
    int done_seen = 0;   // run_done samples
    int wait_viol = 0;   // ap_start still high the cycle after ap_ready was taken
    int done_base = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Callee: reacts one settle delay after each rising clock edge.
    initial begin
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        ap_idle  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ap_start && rst_n) begin
                if (mode == MODE_NORMAL) begin
                    @(posedge clk); #1;
                    ap_ready = 1'b1;
                    ap_idle  = 1'b0;
                    @(posedge clk); #1;
                    ap_ready = 1'b0;
                    repeat (3) begin @(posedge clk); #1; end
                    ap_done = 1'b1;
                    @(posedge clk); #1;
                    ap_done = 1'b0;
                    ap_idle = 1'b1;
                end else if (mode == MODE_COMB) begin
                    ap_ready = 1'b1;
                    ap_done  = 1'b1;
                    @(posedge clk); #1;
                    ap_ready = 1'b0;
                    ap_done  = 1'b0;
                end
            end
        end
    end

    // Monitor: scores each run_done pulse and tracks ap_start behaviour.
    initial begin
        logic           prev_start;
        logic           prev_ready;
        logic [CNT_W:0] exp;
        prev_start = 1'b0;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (run_done) begin
                done_seen++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_run_done: got pulse with done_count=%0d, none expected", done_count);
                end else begin
                    exp = sb_q.pop_front();
                    check("sb_done_count", 64'(done_count), 64'(exp[CNT_W:1]));
                    check("sb_timeout_err", 64'(timeout_err), 64'(exp[0]));
                end
            end
            if (ap_start && !prev_start) episodes++;
            if (prev_ready && ap_start) wait_viol++;
            prev_start = ap_start;
            prev_ready = ap_ready;
        end
    end

    // Issue a run at a negedge; returns at the negedge after the accepting edge.
    task automatic issue_run(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] exp_done,
                             input logic exp_terr, input logic push);
        int n;
        n = 0;
        while (!run_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("run_ready_before_issue", 64'(run_ready), 64'(1));
        done_base = done_seen;
        run_valid = 1'b1;
        run_count = cnt;
        if (push) sb_q.push_back({exp_done, exp_terr});
        @(negedge clk);
        run_valid = 1'b0;
    endtask

    // Wait for the run's run_done with a cycle budget; reports ap_start-high cycles.
    task automatic wait_done(input string name, output int hi_cnt);
        hi_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            if (ap_start) hi_cnt++;
            if (done_seen != done_base) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check({name, "_run_done_pulses"}, 64'(done_seen - done_base), 64'(1));
        check({name, "_busy_low"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int ep0, wv0, hi;
        logic [KEY_W-1:0] key_snap;
        int kr_bad;
        logic found;
        logic prev_rdy;

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_data  = '0;
        run_valid = 1'b0;
        run_count = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_key_ready", 64'(key_ready), 64'(1));
        check("rst_run_ready", 64'(run_ready), 64'(0));
        check("rst_ap_start", 64'(ap_start), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_key_loaded", 64'(key_loaded), 64'(0));
        check("rst_counts", 64'({done_count, timeout_err, run_done}), 64'(0));
        check("rst_working_key", 64'(|working_key), 64'(0));

        // Key load: words 0x00..0x2F
        for (int i = 0; i < 48; i++) begin
            key_valid = 1'b1;
            key_data  = WORD_W'(i);
            @(negedge clk);
            if (i == 1)  check("key_word1_visible", 64'(working_key[63:32]), 64'(1));
            if (i == 46) check("key_loaded_before_last", 64'(key_loaded), 64'(0));
        end
        check("key_loaded_after_last", 64'(key_loaded), 64'(1));
        check("run_ready_blocked_by_key_valid", 64'(run_ready), 64'(0));
        key_valid = 1'b0;
        #1;
        check("run_ready_after_load", 64'(run_ready), 64'(1));
        check("key_word0", 64'(working_key[31:0]), 64'(0));
        check("key_word20", 64'(working_key[20*32 +: 32]), 64'(20));
        check("key_top_truncated", 64'(working_key[1534:1504]), 64'(31'h2F));

        // Three invocations, delayed callee
        mode = MODE_NORMAL;
        ep0 = episodes;
        wv0 = wait_viol;
        issue_run(16'd3, 16'd3, 1'b0, 1'b1);
        check("arm_cycle_ap_start_low", 64'(ap_start), 64'(0));
        @(negedge clk);
        check("start_cycle_ap_start_high", 64'(ap_start), 64'(1));
        wait_done("run3", hi);
        check("run3_start_episodes", 64'(episodes - ep0), 64'(3));
        check("run3_no_start_in_wait", 64'(wait_viol - wv0), 64'(0));

        // Two invocations, combinational callee
        mode = MODE_COMB;
        ep0 = episodes;
        wv0 = wait_viol;
        issue_run(16'd2, 16'd2, 1'b0, 1'b1);
        wait_done("comb2", hi);
        check("comb2_start_episodes", 64'(episodes - ep0), 64'(2));
        check("comb2_start_high_cycles", 64'(hi), 64'(2));
        check("comb2_no_start_after_ready", 64'(wait_viol - wv0), 64'(0));

        // Zero-count run
        ep0 = episodes;
        issue_run(16'd0, 16'd0, 1'b0, 1'b1);
        check("zero_run_done_next_cycle", 64'(run_done), 64'(1));
        check("zero_ap_start_low", 64'(ap_start), 64'(0));
        wait_done("zero", hi);
        check("zero_start_episodes", 64'(episodes - ep0), 64'(0));

        // Hung callee: timeout after TIMEOUT cycles of ap_start
        mode = MODE_HANG;
        issue_run(16'd4, 16'd0, 1'b1, 1'b1);
        wait_done("hang", hi);
        check("hang_start_high_cycles", 64'(hi), 64'(TIMEOUT));
        check("hang_ap_start_dropped", 64'(ap_start), 64'(0));
        repeat (5) @(negedge clk);
        check("timeout_err_sticky", 64'(timeout_err), 64'(1));
        issue_run(16'd0, 16'd0, 1'b0, 1'b1);
        wait_done("clear", hi);
        check("timeout_err_cleared", 64'(timeout_err), 64'(0));
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        // Key words during a run, then reset in WAIT
        mode = MODE_NORMAL;
        issue_run(16'd2, 16'd0, 1'b0, 1'b0);
        key_snap  = working_key;
        key_valid = 1'b1;
        key_data  = 32'hDEAD_BEEF;
        kr_bad    = 0;
        found     = 1'b0;
        prev_rdy  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (key_ready) kr_bad++;
            if (prev_rdy && !ap_start && busy) begin
                found = 1'b1;
                break;
            end
            prev_rdy = ap_ready;
        end
        check("reached_wait", 64'(found), 64'(1));
        check("key_ready_low_in_run", 64'(kr_bad), 64'(0));
        check("working_key_stable_in_run", 64'(working_key == key_snap), 64'(1));
        check("run_ready_low_in_run", 64'(run_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        check("midrun_rst_ap_start", 64'(ap_start), 64'(0));
        check("midrun_rst_busy", 64'(busy), 64'(0));
        check("midrun_rst_key_loaded", 64'(key_loaded), 64'(0));
        check("midrun_rst_working_key", 64'(|working_key), 64'(0));
        check("midrun_rst_counts", 64'({done_count, timeout_err, run_done}), 64'(0));
        check("midrun_rst_key_ready", 64'(key_ready), 64'(1));
        sb_q.delete();
        key_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_run_ready", 64'(run_ready), 64'(0));
        check("post_rst_idle", 64'({ap_start, busy}), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
